// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: segment indices, glyph table and decoder.
// Used by both the display controller and the capture side so the two ends
// can never disagree on a glyph.
package seven_seg_pkg;

  // Segment bit positions within a cathode word (active-high, gfedcba).
  typedef enum int unsigned {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_idx_t;

  localparam int unsigned SEG_W        = 32'(SEG_G) + 1;
  localparam int unsigned NIBBLE_W     = 4;
  localparam int unsigned NUM_PATTERNS = 16;

  // Active-high glyph for each hex value, index = nibble.
  localparam logic [SEG_W-1:0] SEG_PATTERN [NUM_PATTERNS] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Classification of the (normalized) anode bus.
  typedef enum logic [1:0] {
    AN_IDLE  = 2'd0,
    AN_ONE   = 2'd1,
    AN_MULTI = 2'd2
  } anode_class_t;

  typedef struct packed {
    logic                legal;
    logic [NIBBLE_W-1:0] nibble;
  } seg_decode_t;

  // Reverse lookup of an active-high cathode pattern; legal=0 for non-glyphs.
  function automatic seg_decode_t seg_decode(input logic [SEG_W-1:0] pattern);
    seg_decode_t r;
    r.legal  = 1'b0;
    r.nibble = '0;
    for (int unsigned i = 0; i < NUM_PATTERNS; i++) begin
      if (pattern == SEG_PATTERN[i]) begin
        r.legal  = 1'b1;
        r.nibble = NIBBLE_W'(i);
      end
    end
    return r;
  endfunction

  // Forward lookup, used by the driving side of the bus.
  function automatic logic [SEG_W-1:0] seg_encode(input logic [NIBBLE_W-1:0] nibble);
    return SEG_PATTERN[nibble];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of quasi-static asynchronous lines.
// Resets to a caller-chosen idle level so no false edge appears after reset.
module sync_2ff #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/seven_seg_capture.sv
// Receive-side decoder for a multiplexed seven-segment bus. Each one-hot
// digit strobe is sampled once after it has been stable for SETTLE_CYCLES,
// its glyph is decoded back to a nibble, and complete frames / illegal
// patterns are flagged.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_SEGMENTS  = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_SEGMENTS-1:0]                anode,
  input  logic [SEG_W-1:0]                       cathode,
  input  logic                                   err_clr,
  output logic [NUM_SEGMENTS-1:0][NIBBLE_W-1:0]  digits,
  output logic [NUM_SEGMENTS-1:0]                digit_valid,
  output logic                                   frame_valid,
  output logic                                   decode_err
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);

  // Pin level of an undriven bus, so the synchronizers leave reset "idle".
  localparam logic [NUM_SEGMENTS-1:0] AN_IDLE_PIN  = ACTIVE_LOW ? {NUM_SEGMENTS{1'b1}} : '0;
  localparam logic [SEG_W-1:0]        CAT_IDLE_PIN = ACTIVE_LOW ? {SEG_W{1'b1}} : '0;

  // Synchronized pin-level bus and its active-high view.
  logic [NUM_SEGMENTS-1:0] anode_sync;
  logic [SEG_W-1:0]        cathode_sync;
  logic [NUM_SEGMENTS-1:0] an_n;
  logic [SEG_W-1:0]        cat_n;

  // Previous-cycle bus snapshot and settle tracking.
  logic [NUM_SEGMENTS-1:0] an_prev_q;
  logic [SEG_W-1:0]        cat_prev_q;
  logic [CNT_W-1:0]        cnt_q,     cnt_d;
  logic                    sampled_q, sampled_d;

  // Decode results and frame tracking.
  logic [NUM_SEGMENTS-1:0][NIBBLE_W-1:0] digits_q, digits_d;
  logic [NUM_SEGMENTS-1:0]               valid_q,  valid_d;
  logic [NUM_SEGMENTS-1:0]               seen_q,   seen_d;
  logic                                  frame_q,  frame_d;
  logic                                  err_q,    err_d;

  anode_class_t            an_class;
  seg_decode_t             dec;
  logic                    stable;
  logic                    sample;
  logic                    err_set;
  logic [NUM_SEGMENTS-1:0] seen_next;

  sync_2ff #(
    .WIDTH     (NUM_SEGMENTS),
    .RESET_VAL (AN_IDLE_PIN)
  ) u_sync_anode (
    .clk (clk),
    .rst (rst),
    .d_i (anode),
    .q_o (anode_sync)
  );

  sync_2ff #(
    .WIDTH     (SEG_W),
    .RESET_VAL (CAT_IDLE_PIN)
  ) u_sync_cathode (
    .clk (clk),
    .rst (rst),
    .d_i (cathode),
    .q_o (cathode_sync)
  );

  assign an_n  = ACTIVE_LOW ? ~anode_sync   : anode_sync;
  assign cat_n = ACTIVE_LOW ? ~cathode_sync : cathode_sync;

  // Classify the strobe: none (blanking), exactly one digit, or a bus fault.
  always_comb begin
    an_class = AN_IDLE;
    if (an_n != '0) begin
      an_class = ((an_n & (an_n - NUM_SEGMENTS'(1))) == '0) ? AN_ONE : AN_MULTI;
    end
  end

  // Settle counting, single-shot sampling, decode and frame/error bookkeeping.
  always_comb begin
    cnt_d     = cnt_q;
    sampled_d = sampled_q;
    digits_d  = digits_q;
    valid_d   = valid_q;
    seen_d    = seen_q;
    frame_d   = 1'b0;
    err_d     = err_q;
    err_set   = 1'b0;
    seen_next = seen_q;

    stable = (an_n == an_prev_q) && (cat_n == cat_prev_q);

    // Counter only advances on an unchanged one-hot strobe and saturates.
    if (stable && (an_class == AN_ONE)) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end

    // The snapshot being sampled is the one the counter qualified.
    sample = (cnt_q == CNT_MAX) && !sampled_q;
    dec    = seg_decode(cat_prev_q);

    if (sample) begin
      sampled_d = 1'b1;
      for (int unsigned i = 0; i < NUM_SEGMENTS; i++) begin
        if (an_prev_q[i]) begin
          if (dec.legal) begin
            digits_d[i]  = dec.nibble;
            valid_d[i]   = 1'b1;
            seen_next[i] = 1'b1;
          end else begin
            valid_d[i] = 1'b0;
          end
        end
      end
      if (!dec.legal) begin
        err_set = 1'b1;
      end
    end

    // A bus change re-arms sampling for the next strobe.
    if (!stable) begin
      sampled_d = 1'b0;
    end

    if (&seen_next) begin
      frame_d = 1'b1;
      seen_d  = '0;
    end else begin
      seen_d = seen_next;
    end

    if (an_class == AN_MULTI) begin
      err_set = 1'b1;
    end

    // A new error beats a coincident clear.
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_prev_q  <= '0;
      cat_prev_q <= '0;
      cnt_q      <= '0;
      sampled_q  <= 1'b0;
      digits_q   <= '0;
      valid_q    <= '0;
      seen_q     <= '0;
      frame_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      an_prev_q  <= an_n;
      cat_prev_q <= cat_n;
      cnt_q      <= cnt_d;
      sampled_q  <= sampled_d;
      digits_q   <= digits_d;
      valid_q    <= valid_d;
      seen_q     <= seen_d;
      frame_q    <= frame_d;
      err_q      <= err_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign frame_valid = frame_q;
  assign decode_err  = err_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture (4 digits, settle of 4, active-low bus).
// A run-length reference model predicts every output each cycle; directed
// literal checks pin the model at the interesting points.
module tb_seven_seg_capture;

  localparam int unsigned NSEG   = 4;
  localparam int unsigned SETTLE = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NSEG-1:0]      an_pin;
  logic [6:0]           cat_pin;
  logic                 err_clr;
  logic [NSEG-1:0][3:0] digits;
  logic [NSEG-1:0]      digit_valid;
  logic                 frame_valid;
  logic                 decode_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seven_seg_capture #(
    .NUM_SEGMENTS  (NSEG),
    .SETTLE_CYCLES (SETTLE),
    .ACTIVE_LOW    (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .anode       (an_pin),
    .cathode     (cat_pin),
    .err_clr     (err_clr),
    .digits      (digits),
    .digit_valid (digit_valid),
    .frame_valid (frame_valid),
    .decode_err  (decode_err)
  );

  // Reference glyphs (active-high gfedcba), index = hex value.
  logic [6:0] glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Reference model state.
  logic [15:0] m_digits;
  logic [3:0]  m_valid;
  logic [3:0]  m_seen;
  logic        m_frame;
  logic        m_err;
  int          run;
  logic        have_prev;
  logic [10:0] prev_pins;
  // A held strobe counted at pin-sample k shows on the outputs at edge k+3
  // (two sync stages plus the output register); a multi-hot pin at edge k+2.
  logic        ev_v   [3];
  int          ev_pos [3];
  logic [6:0]  ev_cat [3];
  logic        mh     [2];

  task automatic model_reset();
    m_digits  = '0;
    m_valid   = '0;
    m_seen    = '0;
    m_frame   = 1'b0;
    m_err     = 1'b0;
    run       = 0;
    have_prev = 1'b0;
    prev_pins = '0;
    for (int k = 0; k < 3; k++) begin
      ev_v[k]   = 1'b0;
      ev_pos[k] = 0;
      ev_cat[k] = '0;
    end
    mh[0] = 1'b0;
    mh[1] = 1'b0;
  endtask

  task automatic model_edge();
    logic           err_set;
    logic           legal;
    logic [3:0]     nib;
    logic [NSEG-1:0] act;
    int             pos;
    err_set = 1'b0;
    m_frame = 1'b0;
    // Retire the decode that matured this edge.
    if (ev_v[2]) begin
      legal = 1'b0;
      nib   = '0;
      for (int n = 0; n < 16; n++) begin
        if (glyph[n] == ~ev_cat[2]) begin
          legal = 1'b1;
          nib   = 4'(n);
        end
      end
      if (legal) begin
        m_digits[ev_pos[2]*4 +: 4] = nib;
        m_valid[ev_pos[2]]         = 1'b1;
        m_seen[ev_pos[2]]          = 1'b1;
        if (m_seen == 4'hF) begin
          m_frame = 1'b1;
          m_seen  = '0;
        end
      end else begin
        m_valid[ev_pos[2]] = 1'b0;
        err_set            = 1'b1;
      end
    end
    if (mh[1]) err_set = 1'b1;
    if (err_set) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    ev_v[2]   = ev_v[1];   ev_v[1]   = ev_v[0];
    ev_pos[2] = ev_pos[1]; ev_pos[1] = ev_pos[0];
    ev_cat[2] = ev_cat[1]; ev_cat[1] = ev_cat[0];
    mh[1]     = mh[0];
    // Track how long the pins have held their current value.
    if (have_prev && ({an_pin, cat_pin} == prev_pins)) run++;
    else run = 1;
    prev_pins = {an_pin, cat_pin};
    have_prev = 1'b1;
    act = ~an_pin;
    pos = 0;
    for (int b = 0; b < NSEG; b++) begin
      if (act[b]) pos = b;
    end
    ev_v[0]   = (run == SETTLE) && ($countones(act) == 1);
    ev_pos[0] = pos;
    ev_cat[0] = cat_pin;
    mh[0]     = ($countones(act) > 1);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_edge();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Advance n cycles, comparing every output to the model mid-cycle.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      check("cyc_digits", 32'(digits),      32'(m_digits));
      check("cyc_valid",  32'(digit_valid), 32'(m_valid));
      check("cyc_frame",  32'(frame_valid), 32'(m_frame));
      check("cyc_err",    32'(decode_err),  32'(m_err));
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] cat);
    an_pin  = an;
    cat_pin = cat;
  endtask

  initial begin
    rst     = 1'b1;
    err_clr = 1'b0;
    drive(4'hF, 7'h7F);
    step(3);
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_valid",  32'(digit_valid), 32'h0);
    check("rst_frame",  32'(frame_valid), 32'h0);
    check("rst_err",    32'(decode_err), 32'h0);
    rst = 1'b0;
    step(2);

    // Single stable strobe of digit 0 at position 0.
    drive(4'b1110, 7'h40);
    step(6);
    check("s1_valid_early", 32'(digit_valid), 32'h0);
    step(1);
    check("s1_valid", 32'(digit_valid), 32'h1);
    check("s1_digits", 32'(digits), 32'h0);
    step(13);
    check("s1_no_frame", 32'(frame_valid), 32'h0);

    // Scan 1,2,3,F across all positions.
    drive(4'b1110, 7'h79); step(10);
    drive(4'b1101, 7'h24); step(10);
    drive(4'b1011, 7'h30); step(10);
    drive(4'b0111, 7'h0E);
    step(6);
    check("s2_frame_early", 32'(frame_valid), 32'h0);
    step(1);
    check("s2_frame", 32'(frame_valid), 32'h1);
    check("s2_digits", 32'(digits), 32'hF321);
    check("s2_valid", 32'(digit_valid), 32'hF);
    step(1);
    check("s2_frame_pulse", 32'(frame_valid), 32'h0);
    step(2);

    // Glitch: cathode changes on the third cycle of the strobe.
    drive(4'b1110, 7'h24);
    step(3);
    drive(4'b1110, 7'h30);
    step(6);
    check("s3_digits_early", 32'(digits), 32'hF321);
    step(1);
    check("s3_digits", 32'(digits), 32'hF323);
    check("s3_no_frame", 32'(frame_valid), 32'h0);
    step(5);

    // Blank glyph at position 2 is illegal.
    drive(4'b1011, 7'h7F);
    step(7);
    check("s4_err", 32'(decode_err), 32'h1);
    check("s4_valid", 32'(digit_valid), 32'hB);
    check("s4_digits", 32'(digits), 32'hF323);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("s4_err_clr", 32'(decode_err), 32'h0);
    drive(4'hF, 7'h7F);
    step(3);

    // Multi-hot anode; clear collides with a fresh error.
    drive(4'b1100, 7'h40);
    step(2);
    check("s5_err_early", 32'(decode_err), 32'h0);
    step(1);
    check("s5_err", 32'(decode_err), 32'h1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("s5_err_wins", 32'(decode_err), 32'h1);
    step(2);
    check("s5_digits", 32'(digits), 32'hF323);
    check("s5_valid", 32'(digit_valid), 32'hB);
    drive(4'hF, 7'h7F);
    step(3);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("s5_err_clr", 32'(decode_err), 32'h0);

    // Reset in the middle of a strobe, then a full settle afterwards.
    drive(4'b0111, 7'h79);
    step(5);
    rst = 1'b1;
    #1;
    check("s6_async_digits", 32'(digits), 32'h0);
    check("s6_async_valid",  32'(digit_valid), 32'h0);
    check("s6_async_frame",  32'(frame_valid), 32'h0);
    check("s6_async_err",    32'(decode_err), 32'h0);
    step(2);
    rst = 1'b0;
    step(6);
    check("s6_valid_early", 32'(digit_valid), 32'h0);
    step(1);
    check("s6_valid", 32'(digit_valid), 32'h8);
    check("s6_digits", 32'(digits), 32'h1000);
    step(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
